// File: rtl/atm_light_global.sv
// Streaming global atmospheric-light estimator: tracks the brightest-dark pixel of each frame
// and publishes its floored RGB at the frame boundary. Define ATM_IIR_EN to smooth publishes.
module atm_light_global #(
  parameter int         FRAME_PIXELS = 307200,
  parameter int         CNT_W        = 19,
  parameter logic [7:0] A_INIT       = 8'd255,
  parameter logic [7:0] A_FLOOR      = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  output logic [7:0] AR_global,
  output logic [7:0] AG_global,
  output logic [7:0] AB_global,
  output logic       a_valid,
  output logic       a_update,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       best_dark_reg, best_dark_next;
  logic [7:0]       best_rgb_reg [3];
  logic [7:0]       best_rgb_next [3];
  logic [7:0]       a_reg [3];
  logic [7:0]       a_next [3];
  logic             a_valid_reg, a_valid_next;
  logic             a_update_reg, a_update_next;
  logic             frame_err_reg, frame_err_next;

  logic [7:0]       in_rgb [3];
  logic [7:0]       dark;
  logic [7:0]       pub [3];
  logic [CNT_W-1:0] cnt_inc;

  assign in_rgb[0] = in_R;
  assign in_rgb[1] = in_G;
  assign in_rgb[2] = in_B;

  always_comb begin
    dark = in_R;
    if (in_G < dark) dark = in_G;
    if (in_B < dark) dark = in_B;
  end

  assign cnt_inc = cnt_reg + CNT_W'(1);

  // Per-channel publish value: floor the winner, optionally blend with the previous value
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pub
      logic [7:0] cand;
      assign cand = (best_rgb_reg[gi] < A_FLOOR) ? A_FLOOR : best_rgb_reg[gi];
`ifdef ATM_IIR_EN
      logic [9:0] mix;
      assign mix     = 10'd3 * {2'b00, a_reg[gi]} + {2'b00, cand};
      assign pub[gi] = a_valid_reg ? mix[9:2] : cand;
`else
      assign pub[gi] = cand;
`endif
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    best_dark_next = best_dark_reg;
    best_rgb_next  = best_rgb_reg;
    a_next         = a_reg;
    a_valid_next   = a_valid_reg;
    a_update_next  = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            best_dark_next = dark;
            best_rgb_next  = in_rgb;
            cnt_next       = CNT_W'(1);
            state_next     = ACCUM;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end

      ACCUM: begin
        if (in_valid) begin
          if (in_sof) begin
            // Short frame: abandon the partial frame and restart from this pixel
            frame_err_next = 1'b1;
            best_dark_next = dark;
            best_rgb_next  = in_rgb;
            cnt_next       = CNT_W'(1);
          end else begin
            cnt_next = cnt_inc;
            if (dark > best_dark_reg) begin
              best_dark_next = dark;
              best_rgb_next  = in_rgb;
            end
            if (cnt_inc == CNT_LAST) state_next = UPDATE;
          end
        end
      end

      UPDATE: begin
        a_next        = pub;
        a_valid_next  = 1'b1;
        a_update_next = 1'b1;
        state_next    = IDLE;
        // The publish uses the registered winner, so seeding the next frame here is safe
        if (in_valid) begin
          if (in_sof) begin
            best_dark_next = dark;
            best_rgb_next  = in_rgb;
            cnt_next       = CNT_W'(1);
            state_next     = ACCUM;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      best_dark_reg <= '0;
      best_rgb_reg  <= '{default: 8'd0};
      a_reg         <= '{default: A_INIT};
      a_valid_reg   <= 1'b0;
      a_update_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      best_dark_reg <= best_dark_next;
      best_rgb_reg  <= best_rgb_next;
      a_reg         <= a_next;
      a_valid_reg   <= a_valid_next;
      a_update_reg  <= a_update_next;
      frame_err_reg <= frame_err_next;
    end
  end

  assign AR_global = a_reg[0];
  assign AG_global = a_reg[1];
  assign AB_global = a_reg[2];
  assign a_valid   = a_valid_reg;
  assign a_update  = a_update_reg;
  assign frame_err = frame_err_reg;

endmodule
